nco_sweep_gen: RTL and testbench
================================

# nco_sweep_gen

Phase/stimulus generator sitting directly upstream of the 16-stage CORDIC rotator. It produces one rotation angle per clock in the CORDIC angle format, along with a constant-amplitude input vector. The angle comes from a phase accumulator with optional linear frequency sweep (chirp). The block also delays its sample-valid through a latency-matched shift register, so downstream logic knows which CORDIC output cycles carry real samples.

## Interface
- PHASE_W, 32: angle/frequency width. Angle format: bit31 = -180°, bit30 = 90°, LSB = 180°/2^31, two's complement, natural wrap.
- CORDIC_LAT, 16: clock cycles from angle presented at the CORDIC input to the matching CORDIC output.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  write cfg_* into configuration registers; honoured only in IDLE
- cfg_phase0  in  32  initial phase
- cfg_freq0  in  32  initial phase increment per sample (signed)
- cfg_step  in  32  increment added to frequency per sample (signed; 0 = fixed tone)
- cfg_len  in  16  samples per burst; 0 = continuous until stop
- cfg_amp  in  16  signed amplitude driven on xin
- start  in  1  begin burst (IDLE only)
- stop  in  1  end burst after the current sample (RUN only)
- zangle  out  32  angle to the CORDIC
- xin  out  16  cfg_amp while phase_valid, else 0
- yin  out  16  always 0
- phase_valid  out  1  zangle/xin carry a sample this cycle
- out_valid  out  1  CORDIC outputs carry a sample this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last out_valid

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start.
  - RUN → DRAIN after the last sample, when the count reaches cfg_len (cfg_len ≠ 0) or stop is high.
  - DRAIN → DONE after CORDIC_LAT cycles.
  - DONE → IDLE unconditionally.
- Recurrence in RUN:
  - sample 0: phase = phase0, freq = freq0.
  - phase[n+1] = phase[n] + freq[n]; freq[n+1] = freq[n] + step.
  - All arithmetic is modulo 2^32, with no saturation. Crossing +180° wraps to -180°, which is the correct angle.
- stop and the length limit act the same way: the sample on the bus in that cycle is the last one counted. If both occur in the same cycle, there is a single transition.
- cfg_we together with start in IDLE: the burst uses the newly written values (bypass).
- cfg_we, and start, outside IDLE: ignored.
- stop outside RUN: ignored.
- Sample counter is 16 bits. In continuous mode (cfg_len = 0) it is not compared and may wrap freely.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): all outputs 0, state IDLE, config registers 0, valid shift register cleared.
- Reset mid-burst aborts immediately, with no done pulse.
- All outputs are registered.
- start sampled at edge k → phase_valid = 1 and zangle = phase0 from cycle k+1.
- out_valid = phase_valid delayed by exactly CORDIC_LAT cycles.
- Last sample in cycle t gives:
  - phase_valid = 0 from t+1 (DRAIN t+1..t+16);
  - out_valid high at t+16;
  - done = 1 at t+17;
  - busy = 0 from t+18.
- Throughput: one sample per clock, no bubbles within a burst.

## Structure
- Package cordic_pkg holds:
  - PHASE_W, CORDIC_LAT;
  - the FSM state enum;
  - angle constants ANG_90 = 32'h4000_0000, ANG_M180 = 32'h8000_0000.
- The CORDIC rotator uses the same package.
- Sub-module valid_delay_line: parameterised 1-bit shift register (depth CORDIC_LAT, async active-low clear). It is reused wherever CORDIC-latency alignment is needed.

## Test plan
- Fixed tone: phase0 = 0, freq0 = 0x1000_0000, step = 0, len = 4.
  - zangle = 0, 0x1000_0000, 0x2000_0000, 0x3000_0000.
  - phase_valid high 4 cycles, out_valid high 4 cycles starting 16 cycles later, done 17 cycles after the last sample.
- Wrap: phase0 = 0x7000_0000, freq0 = 0x2000_0000, len = 3.
  - zangle = 0x7000_0000, 0x9000_0000, 0xB000_0000, with no glitch.
- Chirp: phase0 = 0, freq0 = 0, step = 0x0100_0000, len = 4.
  - zangle = 0, 0, 0x0100_0000, 0x0300_0000.
- Continuous mode: len = 0, stop high during the 3rd sample.
  - Exactly 3 samples.
  - cfg_we and start during DRAIN are ignored; the config readback is unchanged on the next burst.
- cfg_we and start in the same IDLE cycle with phase0 = 0x4000_0000.
  - First zangle = 0x4000_0000 and xin = the new cfg_amp.
- rst_n pulsed low in the 2nd RUN cycle.
  - All outputs 0 asynchronously, no done, out_valid never asserts.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the phase generator and the CORDIC rotator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cordic_pkg;

    // Angle/frequency width. Bit 31 is -180 deg, bit 30 is 90 deg, and the value wraps naturally.
    localparam int PHASE_W    = 32;
    // Clock cycles from an angle at the rotator input to the matching rotator output.
    localparam int CORDIC_LAT = 16;

    localparam logic [PHASE_W-1:0] ANG_90   = 32'h4000_0000;
    localparam logic [PHASE_W-1:0] ANG_M180 = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// 1-bit shift register that aligns a sample-valid flag with the CORDIC pipeline.
// Latency: DEPTH cycles from din to dout; dout is a flop output.
// Backpressure: none; it shifts every clock.
module valid_delay_line #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    // Shift the valid flag one stage per clock. Reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/nco_sweep_gen.sv
// Phase accumulator with linear chirp; drives angle and amplitude to the CORDIC rotator.
// Latency: first angle is driven 1 cycle after start; out_valid trails phase_valid by CORDIC_LAT.
// Backpressure: none; produces one sample per clock and can be stopped at any sample.
module nco_sweep_gen
    import cordic_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [PHASE_W-1:0] cfg_phase0,
    input  logic [PHASE_W-1:0] cfg_freq0,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [15:0]        cfg_len,
    input  logic [15:0]        cfg_amp,
    input  logic               start,
    input  logic               stop,
    output logic [PHASE_W-1:0] zangle,
    output logic [15:0]        xin,
    output logic [15:0]        yin,
    output logic               phase_valid,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    localparam int DCNT_W = $clog2(CORDIC_LAT + 1);

    state_t               state_q, state_nxt;
    logic                 last_smp;

    logic [PHASE_W-1:0]   phase0_r, freq0_r, step_r;
    logic [15:0]          len_r, amp_r;

    // Bypass values for the first sample, so that a write and start in the same cycle use the new settings.
    logic [PHASE_W-1:0]   sel_phase0, sel_freq0;
    logic [15:0]          sel_amp;

    logic [PHASE_W-1:0]   freq_q;
    logic [15:0]          cnt_q;
    logic [DCNT_W-1:0]    drain_q;

    assign sel_phase0 = cfg_we ? cfg_phase0 : phase0_r;
    assign sel_freq0  = cfg_we ? cfg_freq0  : freq0_r;
    assign sel_amp    = cfg_we ? cfg_amp    : amp_r;

    // Q channel input is always zero.
    assign yin = '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic. stop and the length limit both end the burst after the sample currently on the bus.
    always_comb begin
        state_nxt = state_q;
        last_smp  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                last_smp = stop || ((len_r != 16'd0) && (cnt_q == len_r));
                if (last_smp) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == DCNT_W'(CORDIC_LAT - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Configuration registers. They can be written only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase0_r <= '0;
            freq0_r  <= '0;
            step_r   <= '0;
            len_r    <= '0;
            amp_r    <= '0;
        end else if ((state_q == ST_IDLE) && cfg_we) begin
            phase0_r <= cfg_phase0;
            freq0_r  <= cfg_freq0;
            step_r   <= cfg_step;
            len_r    <= cfg_len;
            amp_r    <= cfg_amp;
        end
    end

    // Phase/frequency recurrence, sample counter and drain timer. All arithmetic wraps modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zangle      <= '0;
            xin         <= '0;
            phase_valid <= 1'b0;
            freq_q      <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        zangle      <= sel_phase0;
                        freq_q      <= sel_freq0;
                        xin         <= sel_amp;
                        phase_valid <= 1'b1;
                        cnt_q       <= 16'd1;
                    end
                end
                ST_RUN: begin
                    if (last_smp) begin
                        zangle      <= '0;
                        xin         <= '0;
                        phase_valid <= 1'b0;
                        drain_q     <= '0;
                    end else begin
                        zangle <= zangle + freq_q;
                        freq_q <= freq_q + step_r;
                        cnt_q  <= cnt_q + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    drain_q <= drain_q + DCNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state, so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state_nxt == ST_DONE);
        end
    end

    valid_delay_line #(
        .DEPTH (CORDIC_LAT)
    ) u_vld_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (phase_valid),
        .dout  (out_valid)
    );

endmodule

// File: tb/tb_nco_sweep_gen.sv
// Self-checking bench for nco_sweep_gen: directed and random bursts against a closed-form phase model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nco_sweep_gen;
    import cordic_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [31:0] cfg_phase0, cfg_freq0, cfg_step;
    logic [15:0] cfg_len, cfg_amp;
    logic        start, stop;
    logic [31:0] zangle;
    logic [15:0] xin, yin;
    logic        phase_valid, out_valid, busy, done;

    int tests = 0;
    int fails = 0;

    // Model of the configuration registers as the bench has written them.
    logic [31:0] m_phase0 = '0, m_freq0 = '0, m_step = '0;
    logic [15:0] m_len = '0, m_amp = '0;

    always #5 clk = ~clk;

    nco_sweep_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_phase0  (cfg_phase0),
        .cfg_freq0   (cfg_freq0),
        .cfg_step    (cfg_step),
        .cfg_len     (cfg_len),
        .cfg_amp     (cfg_amp),
        .start       (start),
        .stop        (stop),
        .zangle      (zangle),
        .xin         (xin),
        .yin         (yin),
        .phase_valid (phase_valid),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Closed form of the chirp: phase[n] = p0 + n*f0 + step*n*(n-1)/2, modulo 2^32.
    function automatic logic [31:0] ref_phase(input logic [31:0] p0, input logic [31:0] f0,
                                              input logic [31:0] st, input int n);
        longint unsigned nn;
        longint unsigned tri_n;
        nn    = longint'(n);
        tri_n = (nn == 0) ? 0 : (nn * (nn - 1)) / 2;
        return p0 + 32'(nn * longint'(f0)) + 32'(tri_n * longint'(st));
    endfunction

    task automatic drive_cfg(input logic [31:0] p0, input logic [31:0] f0, input logic [31:0] st,
                             input logic [15:0] ln, input logic [15:0] am);
        cfg_phase0 = p0;
        cfg_freq0  = f0;
        cfg_step   = st;
        cfg_len    = ln;
        cfg_amp    = am;
    endtask

    task automatic scramble_cfg();
        drive_cfg($urandom, $urandom, $urandom, 16'($urandom), 16'($urandom));
    endtask

    // Run one burst and check every output on every cycle until the block is idle again.
    // wr_mode 0: reuse stored config; 1: write together with start; 2: write one cycle before start.
    // stop_at: 1-based sample index at which stop is raised (0 = never).
    // junk: raise cfg_we/start/stop with random config in the middle of DRAIN.
    task automatic burst(input int wr_mode, input logic [31:0] p0, input logic [31:0] f0,
                         input logic [31:0] st, input logic [15:0] ln, input logic [15:0] am,
                         input int stop_at, input bit junk);
        int n_smp;
        bit exp_pv;
        if (wr_mode != 0) begin
            m_phase0 = p0; m_freq0 = f0; m_step = st; m_len = ln; m_amp = am;
        end
        if (m_len != 0)
            n_smp = (stop_at != 0 && stop_at < int'(m_len)) ? stop_at : int'(m_len);
        else
            n_smp = stop_at;

        @(negedge clk);
        if (wr_mode == 2) begin
            drive_cfg(p0, f0, st, ln, am);
            cfg_we = 1'b1;
            @(negedge clk);
            cfg_we = 1'b0;
            scramble_cfg();
        end else if (wr_mode == 1) begin
            drive_cfg(p0, f0, st, ln, am);
            cfg_we = 1'b1;
        end else begin
            scramble_cfg();
            cfg_we = 1'b0;
        end
        start = 1'b1;

        for (int c = 0; c < n_smp + 20; c++) begin
            @(negedge clk);
            start  = 1'b0;
            cfg_we = 1'b0;
            stop   = 1'b0;
            exp_pv = (c < n_smp);
            chk($sformatf("phase_valid[%0d]", c), 32'(phase_valid), 32'(exp_pv));
            chk($sformatf("out_valid[%0d]", c), 32'(out_valid),
                32'((c >= CORDIC_LAT) && (c < CORDIC_LAT + n_smp)));
            chk($sformatf("done[%0d]", c), 32'(done), 32'(c == n_smp + CORDIC_LAT));
            chk($sformatf("busy[%0d]", c), 32'(busy), 32'(c <= n_smp + CORDIC_LAT));
            chk($sformatf("xin[%0d]", c), 32'(xin), exp_pv ? 32'(m_amp) : 32'd0);
            chk($sformatf("yin[%0d]", c), 32'(yin), 32'd0);
            if (exp_pv)
                chk($sformatf("zangle[%0d]", c), zangle, ref_phase(m_phase0, m_freq0, m_step, c));
            if (stop_at != 0 && c == stop_at - 1)
                stop = 1'b1;
            if (junk && c == n_smp + 2) begin
                scramble_cfg();
                cfg_we = 1'b1;
                start  = 1'b1;
                stop   = 1'b1;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_zangle"}, zangle, 32'd0);
        chk({tag, "_xin"}, 32'(xin), 32'd0);
        chk({tag, "_yin"}, 32'(yin), 32'd0);
        chk({tag, "_pv"}, 32'(phase_valid), 32'd0);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ln_r, stop_r;

        rst_n  = 1'b0;
        cfg_we = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        drive_cfg('0, '0, '0, '0, '0);
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed tone.
        burst(1, 32'h0000_0000, 32'h1000_0000, 32'h0, 16'd4, 16'h1234, 0, 1'b0);
        // Wrap through +180 deg, config written one cycle ahead of start.
        burst(2, 32'h7000_0000, 32'h2000_0000, 32'h0, 16'd3, 16'h7FFF, 0, 1'b0);
        // Chirp.
        burst(1, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000, 16'd4, 16'h8001, 0, 1'b0);
        // Continuous, stopped on the 3rd sample, with writes/start/stop during DRAIN.
        burst(1, 32'h1234_5678, 32'h0ABC_0000, 32'h0001_0000, 16'd0, 16'h0F0F, 3, 1'b1);
        // Reuse the stored config: must be unaffected by the DRAIN writes above.
        burst(0, '0, '0, '0, '0, '0, 5, 1'b0);
        // Write and start in the same cycle.
        burst(1, ANG_90, 32'h0000_1000, 32'h0, 16'd2, 16'h5A5A, 0, 1'b0);
        // Length limit and stop in the same cycle.
        burst(1, 32'hDEAD_BEEF, 32'hF000_0000, 32'h0000_0003, 16'd3, 16'h0001, 3, 1'b0);

        // Random bursts.
        for (int i = 0; i < 6; i++) begin
            ln_r   = $urandom_range(0, 6);
            stop_r = (ln_r == 0) ? $urandom_range(1, 6) : $urandom_range(0, 8);
            burst($urandom_range(1, 2), $urandom, $urandom, $urandom, 16'(ln_r),
                  16'($urandom), stop_r, 1'($urandom_range(0, 1)));
        end

        // Reset in the 2nd RUN cycle: asynchronous clear, no done, no out_valid.
        @(negedge clk);
        drive_cfg(ANG_M180, 32'h0100_0000, 32'h0, 16'd10, 16'h4444);
        cfg_we = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        start  = 1'b0;
        chk("rst_pv0", 32'(phase_valid), 32'd1);
        @(negedge clk);
        chk("rst_z1", zangle, ref_phase(ANG_M180, 32'h0100_0000, 32'h0, 1));
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        m_phase0 = '0; m_freq0 = '0; m_step = '0; m_len = '0; m_amp = '0;
        for (int c = 0; c < CORDIC_LAT + 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_ov[%0d]", c), 32'(out_valid), 32'd0);
            chk($sformatf("post_rst_done[%0d]", c), 32'(done), 32'd0);
            chk($sformatf("post_rst_busy[%0d]", c), 32'(busy), 32'd0);
        end
        // Config registers were cleared by reset: a continuous burst now yields zero angles and amplitude.
        burst(0, '0, '0, '0, '0, '0, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
